// File: rtl/pulse_period_meter_pkg.sv
// Shared types and default parameters for the pulse period meter.
// The optional glitch filter is enabled with `define PULSE_METER_GLITCH_FILTER_EN.
package pulse_period_meter_pkg;

    localparam int unsigned DEF_CNT_W          = 24;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 12000000;
    localparam int unsigned DEF_FILT_LEN       = 4;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } meter_state_t;

endpackage

// File: rtl/pulse_sync_filter.sv
// Two-flop synchronizer plus optional glitch filter producing the filtered level.
// Filter present only when PULSE_METER_GLITCH_FILTER_EN is defined.
module pulse_sync_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic sysclk,
    input  logic reset,
    input  logic pulse_in,
    output logic level
);

`ifdef PULSE_METER_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif
    localparam int unsigned FILT_N = FILT_ON ? FILT_LEN : 0;

    logic [1:0] sync_q;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pulse_in};
        end
    end

    generate
        if (FILT_N > 0) begin : g_filter
            localparam int unsigned FW = (FILT_N > 1) ? $clog2(FILT_N) : 1;
            logic [FW-1:0] run_cnt;
            logic          filt_q;

            // run_cnt counts consecutive samples that disagree with the accepted level
            always_ff @(posedge sysclk or posedge reset) begin
                if (reset) begin
                    run_cnt <= '0;
                    filt_q  <= 1'b0;
                end else if (sync_q[1] == filt_q) begin
                    run_cnt <= '0;
                end else if (run_cnt == FW'(FILT_N - 1)) begin
                    run_cnt <= '0;
                    filt_q  <= sync_q[1];
                end else begin
                    run_cnt <= run_cnt + FW'(1);
                end
            end

            assign level = filt_q;
        end else begin : g_bypass
            assign level = sync_q[1];
        end
    endgenerate

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of a sampled pulse waveform, strobing Valid per period.
// Optional glitch filter: define PULSE_METER_GLITCH_FILTER_EN.
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILT_LEN       = DEF_FILT_LEN
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Pulse_In,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] High_Time,
    output logic             Valid,
    output logic             Timeout,
    output logic             Level
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    meter_state_t     state, state_nx;
    logic             level_d;
    logic             rise, fall, at_limit;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [CNT_W-1:0] high_reg, high_nx;
    logic [CNT_W-1:0] period_nx, high_time_nx;
    logic             valid_nx, timeout_nx;

    pulse_sync_filter #(
        .FILT_LEN(FILT_LEN)
    ) u_sync_filter (
        .sysclk  (sysclk),
        .reset   (reset),
        .pulse_in(Pulse_In),
        .level   (Level)
    );

    assign rise     = Level & ~level_d;
    assign fall     = ~Level & level_d;
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_ONE;
    assign at_limit = (cnt >= TIMEOUT_LIM);

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt_inc;
        high_nx      = high_reg;
        period_nx    = Period;
        high_time_nx = High_Time;
        valid_nx     = 1'b0;
        timeout_nx   = Timeout;

        unique case (state)
            WAIT_RISE: begin
                if (rise) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = HIGH;
                end else if (at_limit) begin
                    timeout_nx = 1'b1;
                    cnt_nx     = '0;
                end
            end
            HIGH: begin
                if (at_limit) begin
                    timeout_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = WAIT_RISE;
                end else if (fall) begin
                    high_nx  = cnt;
                    state_nx = LOW;
                end
            end
            LOW: begin
                // a rise on the threshold cycle still completes the measurement
                if (rise) begin
                    period_nx    = cnt;
                    high_time_nx = high_reg;
                    valid_nx     = 1'b1;
                    timeout_nx   = 1'b0;
                    cnt_nx       = CNT_ONE;
                    state_nx     = HIGH;
                end else if (at_limit) begin
                    timeout_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = WAIT_RISE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = WAIT_RISE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_RISE;
            cnt       <= '0;
            high_reg  <= '0;
            level_d   <= 1'b0;
            Period    <= '0;
            High_Time <= '0;
            Valid     <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            high_reg  <= high_nx;
            level_d   <= Level;
            Period    <= period_nx;
            High_Time <= high_time_nx;
            Valid     <= valid_nx;
            Timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: event-level reference model over the
// driven waveform history, plus directed timeout/reset checks on a second instance.
module tb_pulse_period_meter;

    localparam int FILT = 4;
`ifdef PULSE_METER_GLITCH_FILTER_EN
    localparam int LAT_X = FILT;
`else
    localparam int LAT_X = 0;
`endif
    localparam int DRAIN = 10 + LAT_X;

    logic        sysclk   = 1'b0;
    logic        reset    = 1'b1;
    logic        pulse_in = 1'b0;
    logic        pin_to   = 1'b0;
    logic [7:0]  period, high_time;
    logic        valid, timeout, level;
    logic [15:0] to_period, to_high;
    logic        to_valid, to_timeout, to_level;

    int n_assert = 0;
    int n_fail   = 0;
    bit pin_hist[$];
    int exp_per[$], exp_hi[$];
    int obs_per[$], obs_hi[$];
    int obs_base = 0;
    int checked  = 0;

    pulse_period_meter #(
        .CNT_W         (8),
        .TIMEOUT_CYCLES(250),
        .FILT_LEN      (FILT)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .Pulse_In (pulse_in),
        .Period   (period),
        .High_Time(high_time),
        .Valid    (valid),
        .Timeout  (timeout),
        .Level    (level)
    );

    pulse_period_meter #(
        .CNT_W         (16),
        .TIMEOUT_CYCLES(100),
        .FILT_LEN      (FILT)
    ) dut_to (
        .sysclk   (sysclk),
        .reset    (reset),
        .Pulse_In (pin_to),
        .Period   (to_period),
        .High_Time(to_high),
        .Valid    (to_valid),
        .Timeout  (to_timeout),
        .Level    (to_level)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (!reset && valid === 1'b1) begin
            obs_per.push_back(int'(period));
            obs_hi.push_back(int'(high_time));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = v;
            pin_hist.push_back(v);
            step();
        end
    endtask

    // Filtered level from the driven samples, then one measurement per pair of rises.
    task automatic compute_expected();
        bit lvl, prev, have_rise, stable;
        int last_rise, last_fall;
        exp_per.delete();
        exp_hi.delete();
        lvl = 1'b0; have_rise = 1'b0; last_rise = 0; last_fall = 0;
        for (int t = 0; t < pin_hist.size(); t++) begin
            prev = lvl;
`ifdef PULSE_METER_GLITCH_FILTER_EN
            if (t + 1 >= FILT) begin
                stable = 1'b1;
                for (int j = 0; j < FILT; j++)
                    if (pin_hist[t - j] == lvl) stable = 1'b0;
                if (stable) lvl = ~lvl;
            end
`else
            stable = 1'b1;
            if (stable) lvl = pin_hist[t];
`endif
            if (lvl && !prev) begin
                if (have_rise) begin
                    exp_per.push_back(t - last_rise);
                    exp_hi.push_back(last_fall - last_rise);
                end
                have_rise = 1'b1;
                last_rise = t;
            end
            if (!lvl && prev) last_fall = t;
        end
    endtask

    task automatic check_phase(input string tag);
        drive(pulse_in, DRAIN);
        compute_expected();
        chk({tag, "_count"}, obs_per.size() - obs_base, exp_per.size());
        for (int i = checked; i < exp_per.size(); i++) begin
            if (obs_base + i < obs_per.size()) begin
                chk({tag, "_period"}, obs_per[obs_base + i], exp_per[i]);
                chk({tag, "_high"}, obs_hi[obs_base + i], exp_hi[i]);
            end
        end
        checked = exp_per.size();
        chk({tag, "_no_timeout"}, timeout, 0);
    endtask

    task automatic restart_bookkeeping();
        obs_base = obs_per.size();
        pin_hist.delete();
        checked = 0;
    endtask

    initial begin
        int h, l;

        // reset values
        repeat (3) step();
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_level", level, 0);
        chk("rst_to_period", to_period, 0);
        chk("rst_to_level", to_level, 0);
        reset = 1'b0;

        // timeout on the second instance (threshold 100)
        for (int p = 0; p < 4; p++) begin
            pin_to = 1'b1; repeat (10) step();
            pin_to = 1'b0; repeat (10) step();
        end
        repeat (102 + LAT_X - 20) step();
        chk("to_before_flag", to_timeout, 0);
        chk("to_before_period", to_period, 20);
        chk("to_before_high", to_high, 10);
        step();
        chk("to_flag_set", to_timeout, 1);
        chk("to_period_held", to_period, 20);
        chk("to_high_held", to_high, 10);
        pin_to = 1'b1; repeat (8) step();
        pin_to = 1'b0; repeat (12) step();
        pin_to = 1'b1; repeat (2 + LAT_X) step();
        chk("to_resume_no_valid", to_valid, 0);
        chk("to_resume_still_set", to_timeout, 1);
        step();
        chk("to_resume_valid", to_valid, 1);
        chk("to_resume_cleared", to_timeout, 0);
        chk("to_resume_period", to_period, 20);
        chk("to_resume_high", to_high, 8);
        pin_to = 1'b0;

        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        restart_bookkeeping();

        // square wave 10/10
        drive(1'b0, 5);
        for (int p = 0; p < 6; p++) begin
            drive(1'b1, 10);
            drive(1'b0, 10);
        end
        check_phase("square");

        // narrow high pulse 1/7
        for (int p = 0; p < 5; p++) begin
            drive(1'b1, 1);
            drive(1'b0, 7);
        end
        drive(1'b1, 1);
        check_phase("narrow");

        // random high/low widths
        drive(1'b0, 6);
        for (int p = 0; p < 12; p++) begin
            h = $urandom_range(40, 4);
            l = $urandom_range(40, 4);
            drive(1'b1, h);
            drive(1'b0, l);
        end
        drive(1'b1, 4);
        check_phase("random");

        // 2-cycle glitch inside a 40-cycle period
        drive(1'b0, 8);
        drive(1'b1, 20);
        drive(1'b0, 8);
        drive(1'b1, 2);
        drive(1'b0, 10);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 4);
        check_phase("glitch");

        // 200-cycle period against an 8-bit counter, threshold 250
        drive(1'b0, 40);
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 120);
            drive(1'b0, 80);
        end
        drive(1'b1, 4);
        check_phase("long");

        // reset in the middle of a high phase
        drive(1'b0, 10);
        drive(1'b1, 8);
        compute_expected();
        if (exp_per.size() > 0)
            chk("pre_reset_period", period, exp_per[exp_per.size() - 1]);
        reset = 1'b1;
        #1;
        chk("mid_rst_period", period, 0);
        chk("mid_rst_high", high_time, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_level", level, 0);
        pulse_in = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        restart_bookkeeping();
        drive(1'b0, 3);
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 7);
            drive(1'b0, 13);
        end
        drive(1'b1, 4);
        check_phase("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
